// File: rtl/mux_two_ch_rr.sv
// Two-channel valid/ready merge into a single registered output stage.
// Round-robin arbitration by default; define MUX_FIXED_PRIORITY_EN for channel-0 priority.
module mux_two_ch_rr #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x0,
  input  logic              x0_valid,
  output logic              x0_ready,
  input  logic [DATA_W-1:0] x1,
  input  logic              x1_valid,
  output logic              x1_ready,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              sel
);

  logic [DATA_W-1:0] r_y;
  logic              r_sel;
  logic              r_y_valid;
  logic              r_ptr;

  logic              w_gnt;
  logic              w_any;
  logic              w_load;
  logic              w_xfer;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    // NOTE: default assigned first so no path leaves w_gnt unassigned (no latch).
    w_gnt = 1'b0;
    if (x0_valid && x1_valid) begin
`ifdef MUX_FIXED_PRIORITY_EN
      w_gnt = 1'b0;
`else
      w_gnt = ~r_ptr;
`endif
    end else if (x1_valid) begin
      w_gnt = 1'b1;
    end
  end

  assign w_any  = x0_valid | x1_valid;
  assign w_load = ~r_y_valid | y_ready;
  // Readies are held low while reset is asserted so nothing is accepted during reset.
  assign w_xfer = w_load & w_any & ~rst;
  assign w_data = w_gnt ? x1 : x0;

  assign x0_ready = w_xfer & ~w_gnt;
  assign x1_ready = w_xfer & w_gnt;

  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y       <= '0;
      r_sel     <= 1'b0;
      r_y_valid <= 1'b0;
      r_ptr     <= 1'b1;
    end else if (w_xfer) begin
      r_y       <= w_data;
      r_sel     <= w_gnt;
      r_y_valid <= 1'b1;
      r_ptr     <= w_gnt;
    end else if (r_y_valid && y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign y       = r_y;
  assign sel     = r_sel;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux_two_ch_rr.sv
// Table-driven bench for mux_two_ch_rr with a scoreboard of accepted words.
module tb_mux_two_ch_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x0, x1, y;
  logic       x0_valid, x1_valid, x0_ready, x1_ready;
  logic       y_valid, y_ready, sel;

  mux_two_ch_rr #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .x0(x0), .x0_valid(x0_valid), .x0_ready(x0_ready),
    .x1(x1), .x1_valid(x1_valid), .x1_ready(x1_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
  );

  always #5 clk = ~clk;

`ifdef MUX_FIXED_PRIORITY_EN
  localparam logic RR = 1'b0;
`else
  localparam logic RR = 1'b1;
`endif

  typedef struct {
    logic [7:0] x0;
    logic       x0v;
    logic [7:0] x1;
    logic       x1v;
    logic       yr;
    logic       rst_pulse;
    logic       exp_r0;
    logic       exp_r1;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       sel;
  } exp_t;

  localparam int N_VEC = 21;
  vec_t vecs [N_VEC];
  exp_t sb [$];
  exp_t last;
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic av, input logic [7:0] b,
                              input logic bv, input logic yr, input logic rp,
                              input logic r0, input logic r1);
    vec_t v;
    v.x0 = a; v.x0v = av; v.x1 = b; v.x1v = bv; v.yr = yr;
    v.rst_pulse = rp; v.exp_r0 = r0; v.exp_r1 = r1;
    return v;
  endfunction

  initial begin
    // Pointer resets to 1, so the first contended grant is channel 0.
    vecs[0]  = mk(8'h00, 0, 8'hA5, 1, 1, 0, 0, 1);
    vecs[1]  = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
    vecs[2]  = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
    vecs[3]  = mk(8'h11, 1, 8'h22, 1, 1, 0, 1, 0);
    vecs[4]  = mk(8'h11, 1, 8'h22, 1, 1, 0, ~RR, RR);
    vecs[5]  = mk(8'h11, 1, 8'h22, 1, 1, 0, 1, 0);
    vecs[6]  = mk(8'h11, 1, 8'h22, 1, 1, 0, ~RR, RR);
    vecs[7]  = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
    vecs[8]  = mk(8'h33, 1, 8'h00, 0, 0, 0, 1, 0);
    vecs[9]  = mk(8'h44, 1, 8'h00, 0, 0, 0, 0, 0);
    vecs[10] = mk(8'h44, 1, 8'h00, 0, 0, 0, 0, 0);
    vecs[11] = mk(8'h44, 1, 8'h00, 0, 0, 0, 0, 0);
    vecs[12] = mk(8'h44, 1, 8'h00, 0, 0, 0, 0, 0);
    vecs[13] = mk(8'h44, 1, 8'h00, 0, 1, 0, 1, 0);
    vecs[14] = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
    vecs[15] = mk(8'h00, 0, 8'h55, 1, 0, 0, 0, 1);
    vecs[16] = mk(8'h00, 0, 8'h00, 0, 0, 1, 0, 0);
    vecs[17] = mk(8'h66, 1, 8'h77, 1, 1, 0, 1, 0);
    vecs[18] = mk(8'h66, 1, 8'h77, 1, 1, 0, ~RR, RR);
    vecs[19] = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
    vecs[20] = mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0);

    // Reset held for 3 cycles with both channels requesting.
    rst = 1'b1; x0 = 8'h11; x1 = 8'h22; x0_valid = 1'b1; x1_valid = 1'b1; y_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_y", 32'(y), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_y_valid", 32'(y_valid), 32'h0);
      check("rst_x0_ready", 32'(x0_ready), 32'h0);
      check("rst_x1_ready", 32'(x1_ready), 32'h0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    last.data = 8'h00; last.sel = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      x0 = vecs[i].x0; x0_valid = vecs[i].x0v;
      x1 = vecs[i].x1; x1_valid = vecs[i].x1v;
      y_ready = vecs[i].yr;
      @(negedge clk);
      check($sformatf("x0_ready[%0d]", i), 32'(x0_ready), 32'(vecs[i].exp_r0));
      check($sformatf("x1_ready[%0d]", i), 32'(x1_ready), 32'(vecs[i].exp_r1));
      check($sformatf("y_valid[%0d]", i), 32'(y_valid), 32'(sb.size() != 0));
      e = (sb.size() != 0) ? sb[0] : last;
      check($sformatf("y[%0d]", i), 32'(y), 32'(e.data));
      check($sformatf("sel[%0d]", i), 32'(sel), 32'(e.sel));
      if (sb.size() != 0 && vecs[i].yr) void'(sb.pop_front());
      if (vecs[i].exp_r0) begin
        e.data = vecs[i].x0; e.sel = 1'b0; sb.push_back(e); last = e;
      end
      if (vecs[i].exp_r1) begin
        e.data = vecs[i].x1; e.sel = 1'b1; sb.push_back(e); last = e;
      end
      if (vecs[i].rst_pulse) begin
        // Asynchronous reset pulse between edges discards the stalled word.
        #1 rst = 1'b1;
        #1;
        check("pulse_y_valid", 32'(y_valid), 32'h0);
        check("pulse_y", 32'(y), 32'h0);
        check("pulse_sel", 32'(sel), 32'h0);
        rst = 1'b0;
        sb.delete();
        last.data = 8'h00; last.sel = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
